// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Consumed by mc_control_fsm, mc_alu_decoder and the bench.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  function automatic logic cmd_defined(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bus: instruction fields in, datapath controls and raw
// write requests out. master = control unit, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int ALU_CTRL_W = 2
);
  logic [1:0]            Op;
  logic [5:0]            Funct;
  logic [3:0]            Rd;
  logic                  IRWrite;
  logic                  NextPC;
  logic                  AdrSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ResultSrc;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  PCS;
  logic                  RegW;
  logic                  MemW;
  logic [1:0]            FlagW;
  logic                  NoWrite;
  logic                  illegal_op;

  modport master (
    input  Op, Funct, Rd,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           RegSrc, ALUControl, PCS, RegW, MemW, FlagW, NoWrite, illegal_op
  );

  modport slave (
    output Op, Funct, Rd,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           RegSrc, ALUControl, PCS, RegW, MemW, FlagW, NoWrite, illegal_op
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation, flag-write and NoWrite decode. Only the EXECUTE states
// see a real operation; NoWrite also persists into ALUWB.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       executing;

  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign executing = (state == EXECUTER) || (state == EXECUTEI);

  // Undefined commands fall through to ADD; CMP is a flag-setting subtract.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (executing) begin
      case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        CMD_CMP: alu_control = ALU_SUB;
        default: alu_control = ALU_ADD;
      endcase
      flag_w[1] = s_bit;
      flag_w[0] = s_bit & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
    end
    if (executing || (state == ALUWB))
      no_write = (cmd == CMD_CMP);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the ARM-subset core (fetch/decode/execute/
// memory/writeback). Optional MC_ILLEGAL_TRAP_EN adds a sticky TRAP state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  mc_control_fsm_if.master    bus
);

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_ctrl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       rd_is_pc;

  assign rd_is_pc = (bus.Rd == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FETCH;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM: state_next = MEMADR;
          OP_BR:  state_next = BRANCH;
          OP_DP: begin
`ifdef MC_ILLEGAL_TRAP_EN
            if (!cmd_defined(bus.Funct[4:1]))
              state_next = TRAP;
            else
`endif
              state_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          end
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_next = TRAP;
`else
            state_next = FETCH;
`endif
          end
        endcase
      end
      MEMADR:   state_next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWR:    state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .state       (state),
    .funct       (bus.Funct),
    .alu_control (alu_ctrl),
    .flag_w      (flag_w),
    .no_write    (no_write)
  );

  assign bus.ALUControl = ALU_CTRL_W'(alu_ctrl);
  assign bus.FlagW      = flag_w;
  assign bus.NoWrite    = no_write;

  // Immediate/register-source selects follow the held instruction once it is
  // in the IR; they stay quiet during fetch and in the trap state.
  always_comb begin
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.RegSrc     = 2'b00;
    bus.PCS        = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.illegal_op = 1'b0;
    if ((state != FETCH) && (state != TRAP)) begin
      bus.ImmSrc = bus.Op;
      bus.RegSrc = {bus.Op == OP_MEM, bus.Op == OP_BR};
    end
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:   bus.ALUSrcB = 2'b01;
      MEMRD:    bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
        bus.PCS       = rd_is_pc;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: bus.ALUSrcB = 2'b00;
      EXECUTEI: bus.ALUSrcB = 2'b01;
      ALUWB: begin
        bus.ResultSrc = 2'b00;
        bus.RegW      = 1'b1;
        bus.PCS       = rd_is_pc;
      end
      BRANCH: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCS       = 1'b1;
      end
      TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        bus.illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench: each instruction is expanded into its
// expected per-cycle control schedule and compared cycle by cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic       illegal_op;
  } ctrl_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;
  ctrl_t sched[$];

  mc_control_fsm_if #(.ALU_CTRL_W(2)) bus ();

  mc_control_fsm #(.ALU_CTRL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t sample();
    ctrl_t v;
    v.IRWrite    = bus.IRWrite;
    v.NextPC     = bus.NextPC;
    v.AdrSrc     = bus.AdrSrc;
    v.ALUSrcA    = bus.ALUSrcA;
    v.ALUSrcB    = bus.ALUSrcB;
    v.ResultSrc  = bus.ResultSrc;
    v.ImmSrc     = bus.ImmSrc;
    v.RegSrc     = bus.RegSrc;
    v.ALUControl = bus.ALUControl;
    v.PCS        = bus.PCS;
    v.RegW       = bus.RegW;
    v.MemW       = bus.MemW;
    v.FlagW      = bus.FlagW;
    v.NoWrite    = bus.NoWrite;
    v.illegal_op = bus.illegal_op;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic ctrl_t fetchVec();
    ctrl_t v = '0;
    v.IRWrite   = 1'b1;
    v.NextPC    = 1'b1;
    v.ALUSrcA   = 2'b01;
    v.ALUSrcB   = 2'b10;
    v.ResultSrc = 2'b10;
    return v;
  endfunction

  function automatic ctrl_t trapVec();
    ctrl_t v = '0;
    v.illegal_op = 1'b1;
    return v;
  endfunction

  // Fields every post-fetch cycle carries for the instruction in the IR.
  function automatic ctrl_t instrVec(input logic [1:0] op);
    ctrl_t v = '0;
    v.ImmSrc = op;
    v.RegSrc = {op == 2'b01, op == 2'b10};
    return v;
  endfunction

  function automatic logic [1:0] aluOf(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      4'b1010: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic buildSchedule(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    ctrl_t v;
    logic [3:0] cmd;
    logic s;
    cmd = funct[4:1];
    s = funct[0];
    sched.delete();
    sched.push_back(fetchVec());
    v = instrVec(op);
    v.ALUSrcA = 2'b01;
    v.ALUSrcB = 2'b10;
    v.ResultSrc = 2'b10;
    sched.push_back(v);
    if (op == 2'b01) begin
      v = instrVec(op);
      v.ALUSrcB = 2'b01;
      sched.push_back(v);
      v = instrVec(op);
      v.AdrSrc = 1'b1;
      if (funct[0]) begin
        sched.push_back(v);
        v = instrVec(op);
        v.ResultSrc = 2'b01;
        v.RegW = 1'b1;
        v.PCS = (rd == 4'd15);
        sched.push_back(v);
      end else begin
        v.MemW = 1'b1;
        sched.push_back(v);
      end
    end else if (op == 2'b00) begin
      v = instrVec(op);
      v.ALUSrcB = funct[5] ? 2'b01 : 2'b00;
      v.ALUControl = aluOf(cmd);
      v.FlagW = {s, s & (aluOf(cmd) <= 2'b01)};
      v.NoWrite = (cmd == 4'b1010);
      sched.push_back(v);
      v = instrVec(op);
      v.RegW = 1'b1;
      v.PCS = (rd == 4'd15);
      v.NoWrite = (cmd == 4'b1010);
      sched.push_back(v);
    end else if (op == 2'b10) begin
      v = instrVec(op);
      v.ALUSrcA = 2'b10;
      v.ALUSrcB = 2'b01;
      v.ResultSrc = 2'b10;
      v.PCS = 1'b1;
      sched.push_back(v);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    bus.Op = op;
    bus.Funct = funct;
    bus.Rd = rd;
  endtask

  // Entered just after the edge that loads FETCH; leaves at the same point.
  task automatic runInstr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd, input string name);
    applyStimulus(op, funct, rd);
    buildSchedule(op, funct, rd);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d", name, i + 1), 32'(sample()), 32'(sched[i]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input string name);
    #1 rst = 1'b0;
    #1 checkOutput({name, "_async"}, 32'(sample()), 32'(fetchVec()));
    @(posedge clk);
    #1 checkOutput({name, "_held"}, 32'(sample()), 32'(fetchVec()));
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] cmdList [5];
    logic [1:0] op;
    logic [3:0] cmd;
    logic [5:0] funct;
    logic [3:0] rd;
    cmdList = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    checkCount = 0;
    failCount = 0;
    rst = 1'b0;
    applyStimulus(2'b01, 6'b011000, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 32'(sample()), 32'(fetchVec()));
    @(posedge clk);
    #1 rst = 1'b1;

    runInstr(2'b01, 6'b011001, 4'd2,  "ldr");
    runInstr(2'b01, 6'b011001, 4'd15, "ldr_pc");
    runInstr(2'b01, 6'b011000, 4'd3,  "str");
    runInstr(2'b00, 6'b000101, 4'd1,  "subs");
    runInstr(2'b00, 6'b001001, 4'd4,  "adds");
    runInstr(2'b00, 6'b000001, 4'd5,  "ands");
    runInstr(2'b00, 6'b111000, 4'd6,  "orr_imm");
    runInstr(2'b00, 6'b010101, 4'd0,  "cmp");
    runInstr(2'b00, 6'b101000, 4'd15, "add_pc");
    runInstr(2'b10, 6'b101010, 4'd0,  "branch");
`ifndef MC_ILLEGAL_TRAP_EN
    runInstr(2'b11, 6'b000000, 4'd0,  "op11");
    runInstr(2'b00, 6'b001111, 4'd7,  "undef_cmd");
`endif

    // Reset asserted while a store is in its memory-write cycle.
    applyStimulus(2'b01, 6'b011000, 4'd3);
    buildSchedule(2'b01, 6'b011000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("str_prerst_c%0d", i + 1), 32'(sample()), 32'(sched[i]));
    end
    pulseReset("rst_memwr");
    runInstr(2'b01, 6'b011000, 4'd3, "str_after_rst");

    for (int n = 0; n < 80; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      op = 2'($urandom_range(0, 2));
      cmd = cmdList[$urandom_range(0, 4)];
`else
      op = 2'($urandom_range(0, 3));
      cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : cmdList[$urandom_range(0, 4)];
`endif
      funct = (op == 2'b00) ? {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))}
                            : 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      runInstr(op, funct, rd, $sformatf("rand%0d_op%0d_f%02h", n, op, funct));
    end

`ifdef MC_ILLEGAL_TRAP_EN
    applyStimulus(2'b11, 6'b000000, 4'd0);
    buildSchedule(2'b11, 6'b000000, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("op11_c%0d", i + 1), 32'(sample()), 32'(sched[i]));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("trap_hold%0d", i), 32'(sample()), 32'(trapVec()));
    end
    pulseReset("rst_trap");
    applyStimulus(2'b00, 6'b011111, 4'd1);
    buildSchedule(2'b00, 6'b011111, 4'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("undef_c%0d", i + 1), 32'(sample()), 32'(sched[i]));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("undef_trap%0d", i), 32'(sample()), 32'(trapVec()));
    end
    pulseReset("rst_undef");
    runInstr(2'b10, 6'b000000, 4'd0, "branch_after_trap");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the ARM-subset core. Sits directly upstream of the conditional-logic stage.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Produces the raw PCS, RegW, MemW, FlagW and NoWrite requests that the conditional-logic stage gates with CondEx.
- Also drives the datapath mux selects, IR/PC enables and ALU control.

Parameters:
ALU_CTRL_W, 2, width of ALUControl; encodings 00 ADD, 01 SUB, 10 AND, 11 ORR.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]: I, cmd[3:0], S
- Rd  in  4  instr[15:12]
- IRWrite  out  1  load instruction register
- NextPC  out  1  unconditional PC write (fetch)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUResult reg
- ALUSrcA  out  2  00 Rn, 01 PC, 10 ALUOut
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ImmSrc  out  2  Op-derived immediate format
- RegSrc  out  2  RegSrc[0] = (Op==10), RegSrc[1] = (Op==01)
- ALUControl  out  ALU_CTRL_W  ALU operation
- PCS  out  1  PC-write request to conditional logic
- RegW  out  1  register-write request
- MemW  out  1  memory-write request
- FlagW  out  2  [1] NZ write, [0] CV write
- NoWrite  out  1  suppress register write (CMP)
- illegal_op  out  1  trap flag (see Optional Feature)

Behaviour:
- State register updates on the rising clk edge. While rst=0 the state is FETCH, asynchronously.
- Outputs are Moore, decoded from the state register. Exceptions: ALUControl, FlagW, NoWrite, ImmSrc and RegSrc are combinational from Funct/Op, qualified by state.
- Reset output values: FETCH decode, i.e. IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=00. All other outputs 0.
- States and transitions:
  - FETCH -> DECODE
  - DECODE -> MEMADR if Op=01
  - DECODE -> EXECUTER if Op=00 and Funct[5]=0
  - DECODE -> EXECUTEI if Op=00 and Funct[5]=1
  - DECODE -> BRANCH if Op=10
  - DECODE -> FETCH if Op=11
  - MEMADR -> MEMRD if Funct[0]=1 (LDR), else MEMWR
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
  - Unused encodings -> FETCH
- Latency in cycles: LDR 5, STR 4, DP 4, B 3, Op=11 2.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (PC+8 read).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=00.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=00. EXECUTEI: ALUSrcB=01. Both use ALUSrcA=00.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCS=1.
- ALUControl in EXECUTE*: cmd 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11, 1010 (CMP) -> 01. Any other cmd -> 00.
- FlagW in EXECUTE* only: FlagW[1] = S; FlagW[0] = S & (ALUControl is ADD or SUB). FlagW is 0 in all other states.
- NoWrite = 1 when cmd=1010, held through ALUWB.
- Rd=15 writeback (DP or LDR): PCS=1 asserted in the writeback state alongside RegW.
- Mid-instruction reset forces FETCH immediately. No partial RegW/MemW pulse may follow reset release.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - Op=11, or an undefined cmd in Op=00, drives DECODE -> TRAP.
  - TRAP holds: all write enables 0, illegal_op=1.
  - TRAP is left only by reset.
- Undefined:
  - illegal_op is tied 0.
  - Op=11 returns to FETCH; undefined cmd executes as ADD.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum typedef (FETCH..BRANCH, TRAP)
  - ALUControl localparams
  - Op encodings: OP_DP=00, OP_MEM=01, OP_BR=10
  - cmd constants
- Sub-module mc_alu_decoder: combinational Funct/state -> ALUControl, FlagW, NoWrite.

Test Plan:
- Reset: rst=0 mid-MEMWR -> next sample shows FETCH outputs, MemW=0. Release rst -> DECODE after 1 clk.
- LDR (Op=01, Funct=011001): exactly 5 cycles. RegW=1 only in cycle 5 with ResultSrc=01. MemW never asserted.
- STR (Funct=011000): MemW=1 in cycle 4 only, AdrSrc=1, RegW=0 throughout.
- SUBS R1 (Op=00, Funct=000101): EXECUTER gives ALUControl=01, FlagW=11. ALUWB gives RegW=1, FlagW=00. ADDS gives FlagW=11; ANDS gives FlagW=10.
- CMP (Funct=010101): ALUControl=01, FlagW=11, NoWrite=1 in ALUWB.
- B (Op=10): PCS=1 in cycle 3, ALUSrcA=10, ALUSrcB=01. Back to FETCH on cycle 4. Op=11 with MC_ILLEGAL_TRAP_EN -> illegal_op=1 held, no writes for 10 cycles.
